// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential 32-bit divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          DIV_WIDTH     = 32;
  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div32_seq_if.sv
// Start/busy/done handshake and operand/result bus between the control unit and div32_seq.
interface div32_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, is_signed,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, is_signed,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the {remainder, quotient} register left and trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0]   dvs,
  output logic [2*WIDTH-1:0] rem_out
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] trial;

  // The bit shifted out of the top is kept as the trial's 33rd bit, since the
  // partial remainder can exceed 32 bits for divisors with the MSB set.
  assign upper = rem_in[2*WIDTH-1:WIDTH-1];
  assign trial = upper - {1'b0, dvs};

  assign rem_out = trial[WIDTH] ? {rem_in[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], rem_in[WIDTH-2:0], 1'b1};

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Signed division (is_signed) is built only when DIV32_SIGNED_EN is defined.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  div32_seq_if.slave  bus
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   work;
  logic [2*WIDTH-1:0]   work_nxt;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     dvd_raw;
  logic                 zero_div;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

`ifdef DIV32_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_q;
  logic neg_r;

  assign neg_a = bus.is_signed & bus.dividend[WIDTH-1];
  assign neg_b = bus.is_signed & bus.divisor[WIDTH-1];
  assign abs_a = neg_a ? -bus.dividend : bus.dividend;
  assign abs_b = neg_b ? -bus.divisor  : bus.divisor;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign q_fix = neg_q ? -work[WIDTH-1:0]       : work[WIDTH-1:0];
  assign r_fix = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
`else
  logic unused_sign;

  assign unused_sign = bus.is_signed;
  assign abs_a = bus.dividend;
  assign abs_b = bus.divisor;
  assign q_fix = work[WIDTH-1:0];
  assign r_fix = work[2*WIDTH-1:WIDTH];
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (work),
    .dvs     (dvs),
    .rem_out (work_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      work            <= '0;
      dvs             <= '0;
      dvd_raw         <= '0;
      zero_div        <= 1'b0;
`ifdef DIV32_SIGNED_EN
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
`endif
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd_raw  <= bus.dividend;
            dvs      <= abs_b;
            work     <= {{WIDTH{1'b0}}, abs_a};
            cnt      <= '0;
            zero_div <= (bus.divisor == '0);
`ifdef DIV32_SIGNED_EN
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
`endif
            bus.busy <= 1'b1;
            state    <= (bus.divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          work <= work_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITERS - 1)) state <= DONE;
        end
        DONE: begin
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.div_by_zero <= zero_div;
          bus.quotient    <= zero_div ? DIV_BY_ZERO_Q : q_fix;
          bus.remainder   <= zero_div ? dvd_raw       : r_fix;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed and random checks of div32_seq against an arithmetic reference model.
module tb_div32_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div32_seq_if #(.WIDTH(32)) bus ();

  div32_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV32_SIGNED_EN
  localparam logic [31:0] Q_M7_2  = 32'hFFFF_FFFD, R_M7_2  = 32'hFFFF_FFFF;
  localparam logic [31:0] Q_7_M2  = 32'hFFFF_FFFD, R_7_M2  = 32'h0000_0001;
  localparam logic [31:0] Q_MIN_1 = 32'h8000_0000, R_MIN_1 = 32'h0000_0000;
`else
  localparam logic [31:0] Q_M7_2  = 32'h7FFF_FFFC, R_M7_2  = 32'h0000_0001;
  localparam logic [31:0] Q_7_M2  = 32'h0000_0000, R_7_M2  = 32'h0000_0007;
  localparam logic [31:0] Q_MIN_1 = 32'h0000_0000, R_MIN_1 = 32'h8000_0000;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    logic   unused_s;
    unused_s = s;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end
`ifdef DIV32_SIGNED_EN
    else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
`endif
    else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Entered and left on a falling edge; the start is sampled on the next rising edge.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int reissue_at);
    int n;
    int busy_low;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " done_after_start"}, 64'(bus.done), 64'd0);
    n        = 0;
    busy_low = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (reissue_at > 0 && n + 1 == reissue_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end else begin
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.is_signed = 1'($urandom);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " latency"},   64'(n),        64'(exp_lat));
    check({tag, " busy_gaps"}, 64'(busy_low), 64'd0);
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " quotient"},  64'(bus.quotient),    64'(eq));
    check({tag, " remainder"}, 64'(bus.remainder),   64'(er));
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edz));
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic        s, dz;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy",      64'(bus.busy),        64'd0);
    check("rst done",      64'(bus.done),        64'd0);
    check("rst quotient",  64'(bus.quotient),    64'd0);
    check("rst remainder", 64'(bus.remainder),   64'd0);
    check("rst dbz",       64'(bus.div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div("u100_7",   32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0);
    do_div("u5_0",     32'd5,   32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b0 | 1'b1, 0);
    do_div("umax_1",   32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    do_div("u3_10",    32'd3,   32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 0);
    do_div("reissue10", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 10);
    do_div("reissue_done", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    do_div("u9_3",     32'd9,   32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 0);
    do_div("s-7_2",    32'hFFFF_FFF9, 32'd2, 1'b1, Q_M7_2, R_M7_2, 1'b0, 0);
    do_div("s7_-2",    32'd7, 32'hFFFF_FFFE, 1'b1, Q_7_M2, R_7_M2, 1'b0, 0);
    do_div("smin_-1",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, Q_MIN_1, R_MIN_1, 1'b0, 0);
    do_div("u-7_2",    32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 0);
    do_div("s-5_0",    32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      a = (i % 6 == 5) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0, 1:    b = $urandom_range(1, 15);
        2, 3:    b = $urandom;
        4, 5:    b = 32'h8000_0000 | $urandom;
        6:       b = 32'hFFFF_FFFF;
        default: b = 32'd0;
      endcase
      s = 1'($urandom);
      model(a, b, s, q, r, dz);
      do_div($sformatf("rnd%0d", i), a, b, s, q, r, dz, 0);
    end

    do_div("pre_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy",      64'(bus.busy),        64'd0);
    check("abort quotient",  64'(bus.quotient),    64'd0);
    check("abort remainder", 64'(bus.remainder),   64'd0);
    check("abort dbz",       64'(bus.div_by_zero), 64'd0);
    s = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
      if (bus.done === 1'b1) s = 1'b1;
    end
    check("abort no_done", 64'(s), 64'd0);
    do_div("u8_3", 32'd8, 32'd3, 1'b0, 32'd2, 32'd2, 1'b0, 0);
    @(negedge clk);
    check("done pulse width", 64'(bus.done), 64'd0);
    check("result held", 64'(bus.quotient), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
